// File: rtl/hemanth_rv32i_pkg.sv
// Shared definitions for the hemanth_rv32i core and its data-memory responder.
package hemanth_rv32i_pkg;

    localparam logic [6:0] M_TYPE = 7'd1;
    localparam logic [2:0] LW     = 3'd0;
    localparam logic [2:0] SW     = 3'd1;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dmem_state_t;

    // Word address is valid only if no bit at or above position aw is set.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> aw) == 32'd0;
    endfunction

endpackage

// File: rtl/hemanth_dmem_responder_if.sv
// Request/response channel between the core memory stage and the data-memory responder.
interface hemanth_dmem_responder_if;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/hemanth_dmem_array.sv
// Single-port DEPTH x 32 word array: synchronous write, registered read.
module hemanth_dmem_array #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // NOTE: storage has no reset; contents are undefined until written, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hemanth_dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, held response.
module hemanth_dmem_responder
    import hemanth_rv32i_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                           clk,
    input  logic                           RN,
    hemanth_dmem_responder_if.slave        bus,
    output logic [7:0]                     rd_count,
    output logic [7:0]                     wr_count
);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              oor_q, oor_d;
    logic              err_q, rd_ok_q;
    logic [7:0]        rd_count_q, wr_count_q;

    // Access fields seen at the commit edge (bypass the latches when there are no wait states).
    logic              commit;
    logic              acc_we, acc_oor;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic [31:0]       arr_rdata;
    logic              arr_en;

    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        oor_d     = oor_q;
        commit    = 1'b0;
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_oor   = oor_q;

        unique case (state_q)
            DM_IDLE: begin
                if (bus.req_valid) begin
                    we_d      = bus.req_we;
                    idx_d     = bus.req_addr[ADDR_W-1:0];
                    wdata_d   = bus.req_wdata;
                    oor_d     = !addr_in_range(bus.req_addr, ADDR_W);
                    acc_we    = we_d;
                    acc_idx   = idx_d;
                    acc_wdata = wdata_d;
                    acc_oor   = oor_d;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DM_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = DM_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            DM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DM_RESP;
                    commit  = 1'b1;
                end
            end
            DM_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = DM_IDLE;
                end
            end
            default: state_d = DM_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (RN) begin
            state_q    <= DM_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            oor_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_ok_q    <= 1'b0;
            rd_count_q <= 8'd0;
            wr_count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            if (commit) begin
                err_q   <= acc_oor;
                rd_ok_q <= !acc_oor && !acc_we;
                if (!acc_oor) begin
                    if (acc_we) wr_count_q <= wr_count_q + 8'd1;
                    else        rd_count_q <= rd_count_q + 8'd1;
                end
            end else if (state_q == DM_RESP && bus.rsp_ready) begin
                err_q   <= 1'b0;
                rd_ok_q <= 1'b0;
            end
        end
    end

    // Reset wins over a commit so a pending write never reaches the array.
    assign arr_en = commit && !acc_oor && !RN;

    hemanth_dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .en_i    (arr_en),
        .we_i    (acc_we),
        .addr_i  (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    assign bus.req_ready = (state_q == DM_IDLE);
    assign bus.rsp_valid = (state_q == DM_RESP);
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = rd_ok_q ? arr_rdata : 32'd0;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_hemanth_dmem_responder.sv
// Randomized bench for hemanth_dmem_responder at WAIT_CYCLES = 1, 4 and 0 against a word-array model.
module tb_hemanth_dmem_responder;

    localparam int N_DUT = 3;
    localparam int WC_TAB [N_DUT] = '{1, 4, 0};

    logic clk;
    logic rn        [N_DUT];
    logic req_valid [N_DUT];
    logic req_we    [N_DUT];
    logic [31:0] req_addr  [N_DUT];
    logic [31:0] req_wdata [N_DUT];
    logic rsp_ready [N_DUT];
    wire  req_ready_w [N_DUT];
    wire  rsp_valid_w [N_DUT];
    wire  rsp_err_w   [N_DUT];
    wire  [31:0] rsp_rdata_w [N_DUT];
    wire  [7:0]  rd_count_w  [N_DUT];
    wire  [7:0]  wr_count_w  [N_DUT];

    int compared   = 0;
    int mismatched = 0;

    // Reference model: plain word arrays with a written flag and modulo-256 counts.
    logic [31:0] m_mem   [N_DUT][32];
    bit          m_known [N_DUT][32];
    int          m_rd    [N_DUT];
    int          m_wr    [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int WC = (g == 0) ? 1 : ((g == 1) ? 4 : 0);
        hemanth_dmem_responder_if bus ();
        assign bus.req_valid = req_valid[g];
        assign bus.req_we    = req_we[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.req_wdata = req_wdata[g];
        assign bus.rsp_ready = rsp_ready[g];
        assign req_ready_w[g] = bus.req_ready;
        assign rsp_valid_w[g] = bus.rsp_valid;
        assign rsp_err_w[g]   = bus.rsp_err;
        assign rsp_rdata_w[g] = bus.rsp_rdata;
        hemanth_dmem_responder #(
            .DEPTH       (32),
            .ADDR_W      (5),
            .WAIT_CYCLES (WC)
        ) dut (
            .clk      (clk),
            .RN       (rn[g]),
            .bus      (bus),
            .rd_count (rd_count_w[g]),
            .wr_count (wr_count_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_all();
        for (int d = 0; d < N_DUT; d++) begin
            rn[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b1;
            m_rd[d] = 0; m_wr[d] = 0;
            for (int a = 0; a < 32; a++) m_known[d][a] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < N_DUT; d++) begin
            rn[d] = 1'b0;
            check("rst_req_ready", 32'(req_ready_w[d]), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid_w[d]), 32'd0);
            check("rst_rsp_rdata", rsp_rdata_w[d], 32'd0);
            check("rst_rsp_err",   32'(rsp_err_w[d]), 32'd0);
            check("rst_rd_count",  32'(rd_count_w[d]), 32'd0);
            check("rst_wr_count",  32'(wr_count_w[d]), 32'd0);
        end
    endtask

    // One full transaction; enters and leaves just after a falling edge.
    task automatic do_txn(input int d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall, input bit junk);
        int k;
        bit exp_err, chk_rd;
        logic [31:0] exp_rdata;

        exp_err = (addr >= 32'd32);
        exp_rdata = 32'd0;
        chk_rd = 1'b1;
        if (!exp_err) begin
            if (we) begin
                m_mem[d][addr] = wdata;
                m_known[d][addr] = 1'b1;
                m_wr[d] = (m_wr[d] + 1) % 256;
            end else begin
                chk_rd = m_known[d][addr];
                exp_rdata = m_mem[d][addr];
                m_rd[d] = (m_rd[d] + 1) % 256;
            end
        end

        check("req_ready_before", 32'(req_ready_w[d]), 32'd1);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
        rsp_ready[d] = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        check("req_ready_busy", 32'(req_ready_w[d]), 32'd0);
        k = 0;
        while (!rsp_valid_w[d] && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("rsp_latency", 32'(k), 32'(WC_TAB[d]));
        check("rsp_err", 32'(rsp_err_w[d]), 32'(exp_err));
        if (chk_rd) check("rsp_rdata", rsp_rdata_w[d], exp_rdata);
        check("rd_count", 32'(rd_count_w[d]), 32'(m_rd[d]));
        check("wr_count", 32'(wr_count_w[d]), 32'(m_wr[d]));

        for (int i = 0; i < stall; i++) begin
            if (junk && i == 0) begin
                req_valid[d] = 1'b1; req_we[d] = 1'b1;
                req_addr[d] = addr; req_wdata[d] = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid_w[d]), 32'd1);
            check("hold_req_ready", 32'(req_ready_w[d]), 32'd0);
            check("hold_rsp_err", 32'(rsp_err_w[d]), 32'(exp_err));
            if (chk_rd) check("hold_rsp_rdata", rsp_rdata_w[d], exp_rdata);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_rsp_valid", 32'(rsp_valid_w[d]), 32'd0);
        check("done_req_ready", 32'(req_ready_w[d]), 32'd1);
        check("done_rsp_rdata", rsp_rdata_w[d], 32'd0);
        check("done_rsp_err",   32'(rsp_err_w[d]), 32'd0);
    endtask

    task automatic random_txns(input int d, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'(32 + $urandom_range(0, 1000)) : 32'($urandom_range(0, 7));
            do_txn(d, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        bit rose;

        reset_all();

        // WAIT_CYCLES = 1
        do_txn(0, 1'b1, 32'd3, 32'h0000_0003, 0, 1'b0);
        do_txn(0, 1'b0, 32'd3, 32'd0, 0, 1'b0);
        do_txn(0, 1'b0, 32'd3, 32'd0, 4, 1'b1);
        do_txn(0, 1'b0, 32'd3, 32'd0, 0, 1'b0);
        do_txn(0, 1'b1, 32'd0, 32'h0000_0011, 0, 1'b0);
        do_txn(0, 1'b1, 32'd32, 32'hDEAD_BEEF, 0, 1'b0);
        do_txn(0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 1, 1'b0);
        do_txn(0, 1'b0, 32'd0, 32'd0, 0, 1'b0);
        do_txn(0, 1'b0, 32'hFFFF_FFE3, 32'd0, 0, 1'b0);
        random_txns(0, 40);

        // WAIT_CYCLES = 4, reset while a write is pending
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'd5; req_wdata[1] = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("midrst_in_wait", 32'(req_ready_w[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rn[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rn[1] = 1'b0;
        m_rd[1] = 0;
        m_wr[1] = 0;
        check("midrst_req_ready", 32'(req_ready_w[1]), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid_w[1]), 32'd0);
        check("midrst_wr_count",  32'(wr_count_w[1]), 32'd0);
        rose = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            rose |= rsp_valid_w[1];
        end
        check("midrst_no_rsp", 32'(rose), 32'd0);
        do_txn(1, 1'b1, 32'd5, 32'h0000_005A, 0, 1'b0);
        do_txn(1, 1'b0, 32'd5, 32'd0, 0, 1'b0);
        random_txns(1, 20);

        // WAIT_CYCLES = 0, write counter wraps after 256 writes
        for (int i = 0; i < 256; i++) begin
            do_txn(2, 1'b1, 32'($urandom_range(0, 31)), $urandom, 0, 1'b0);
        end
        check("wr_count_wrap", 32'(wr_count_w[2]), 32'd0);
        random_txns(2, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
